// File: rtl/i_cache.sv
// i_cache: direct-mapped instruction cache; a miss fetches one block from memory, beat by beat.
// Define I_CACHE_PERF_EN to add the hit_count/miss_count outputs.
`ifndef PC_SIZE
`define PC_SIZE 16
`endif
`ifndef CACHE_BLOCK_SIZE
`define CACHE_BLOCK_SIZE 64
`endif
`ifndef MEM_TRANS_SIZE
`define MEM_TRANS_SIZE 16
`endif

module i_cache #(
    parameter int LINES = 8,
    localparam int OFF_W = $clog2(`CACHE_BLOCK_SIZE / 16),
    localparam int IDX_W = $clog2(LINES),
    localparam int TAG_W = `PC_SIZE - OFF_W - IDX_W,
    localparam int ADDR_W = `PC_SIZE - OFF_W,
    localparam int BEATS = `CACHE_BLOCK_SIZE / `MEM_TRANS_SIZE,
    localparam int CNT_W = BEATS > 1 ? $clog2(BEATS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fetch_req,
    input  logic [`PC_SIZE-1:0]        pc,
    input  logic                       flush,
    output logic                       instr_valid,
    output logic [15:0]                instr,
    output logic                       mem_req,
    output logic [ADDR_W-1:0]          mem_address,
    input  logic                       mem_ack,
    input  logic [`MEM_TRANS_SIZE-1:0] mem_data
`ifdef I_CACHE_PERF_EN
    ,
    output logic [31:0]                hit_count,
    output logic [31:0]                miss_count
`endif
);
    typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

    state_t                      state, next;
    logic [LINES-1:0]            valid_q;
    logic [TAG_W-1:0]            tag_q  [LINES];
    logic [`CACHE_BLOCK_SIZE-1:0] data_q [LINES];
    logic [ADDR_W-1:0]           fill_addr;
    logic [CNT_W-1:0]            beat_cnt;
    logic                        flush_pend;
    logic                        hit;
    logic                        last_beat;
    logic                        start_miss;
    logic [OFF_W-1:0]            pc_off;
    logic [IDX_W-1:0]            pc_idx;
    logic [TAG_W-1:0]            pc_tag;
    logic [IDX_W-1:0]            fill_idx;
    logic [TAG_W-1:0]            fill_tag;
    logic [`CACHE_BLOCK_SIZE-1:0] line;

    assign pc_off      = pc[OFF_W-1:0];
    assign pc_idx      = pc[OFF_W+IDX_W-1:OFF_W];
    assign pc_tag      = pc[`PC_SIZE-1:OFF_W+IDX_W];
    assign fill_idx    = fill_addr[IDX_W-1:0];
    assign fill_tag    = fill_addr[ADDR_W-1:IDX_W];
    assign line        = data_q[pc_idx];
    assign mem_address = fill_addr;

    always_comb begin
        next        = state;
        mem_req     = 1'b0;
        hit         = (state == IDLE) && fetch_req && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
        last_beat   = (state == FILL) && (beat_cnt == CNT_W'(BEATS - 1));
        start_miss  = (state == IDLE) && fetch_req && !hit && !flush;
        instr_valid = hit;
        instr       = hit ? line[32'(pc_off) * 16 +: 16] : 16'h0;
        case (state)
            IDLE: next = start_miss ? REQ : IDLE;
            REQ: begin
                mem_req = 1'b1;
                next    = mem_ack ? FILL : REQ;
            end
            FILL:    next = last_beat ? IDLE : FILL;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            valid_q    <= '0;
            fill_addr  <= '0;
            flush_pend <= 1'b0;
        end else begin
            state      <= next;
            beat_cnt   <= (state == FILL) ? beat_cnt + 1'b1 : '0;
            flush_pend <= (state != IDLE) && (flush_pend || flush);
            if (start_miss)
                fill_addr <= pc[`PC_SIZE-1:OFF_W];
            // A flush seen anywhere during the fill keeps the new line invalid.
            if (flush)
                valid_q <= '0;
            else if (state == REQ && mem_ack)
                valid_q[fill_idx] <= 1'b0;
            else if (last_beat && !flush_pend)
                valid_q[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == FILL)
            data_q[fill_idx][32'(beat_cnt) * `MEM_TRANS_SIZE +: `MEM_TRANS_SIZE] <= mem_data;
        if (last_beat)
            tag_q[fill_idx] <= fill_tag;
    end

`ifdef I_CACHE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit)
                hit_count <= hit_count + 32'd1;
            if (start_miss)
                miss_count <= miss_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_i_cache.sv
// tb_i_cache: directed tests of i_cache against a simple block memory with programmable ack delay.
`ifndef PC_SIZE
`define PC_SIZE 16
`endif
`ifndef CACHE_BLOCK_SIZE
`define CACHE_BLOCK_SIZE 64
`endif
`ifndef MEM_TRANS_SIZE
`define MEM_TRANS_SIZE 16
`endif

module tb_i_cache;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_req = 1'b0;
    logic [15:0] pc = 16'h0;
    logic        flush = 1'b0;
    logic        instr_valid;
    logic [15:0] instr;
    logic        mem_req;
    logic [13:0] mem_address;
    logic        mem_ack;
    logic [15:0] mem_data;
`ifdef I_CACHE_PERF_EN
    logic [31:0] hit_count, miss_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int ack_delay = 0;
    int wait_cnt = 0;
    int beat_q = 0;
    logic [13:0] blk = '0;

    i_cache dut (
        .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .pc(pc), .flush(flush),
        .instr_valid(instr_valid), .instr(instr), .mem_req(mem_req), .mem_address(mem_address),
        .mem_ack(mem_ack), .mem_data(mem_data)
`ifdef I_CACHE_PERF_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] word(input logic [15:0] a);
        return (a * 16'h0101) ^ 16'h3C5A;
    endfunction

    // Memory model: ack after ack_delay cycles of request, then four beats on the following cycles.
    assign mem_ack  = mem_req && (wait_cnt >= ack_delay);
    assign mem_data = (beat_q != 0) ? word({blk, 2'(beat_q - 1)}) : 16'hDEAD;

    always @(posedge clk) begin
        if (mem_ack) begin
            wait_cnt <= 0;
            beat_q   <= 1;
            blk      <= mem_address;
        end else begin
            if (mem_req)
                wait_cnt <= wait_cnt + 1;
            if (beat_q != 0)
                beat_q <= (beat_q == 4) ? 0 : beat_q + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hit(input logic [15:0] a, input string nm);
        int i;
        i = 0;
        while (instr_valid !== 1'b1 && i < 20) begin
            step();
            i++;
        end
        n_cmp++;
        if (instr_valid !== 1'b1 || instr !== word(a)) begin
            n_bad++;
            $display("FAIL %s: valid=%b instr=%h want valid=1 instr=%h", nm, instr_valid, instr, word(a));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        fetch_req = 1'b1;
        pc = 16'h0000;
        repeat (3) step();
        n_cmp++;
        if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: mem_req=%b instr_valid=%b want 0 0", mem_req, instr_valid);
        end
`ifdef I_CACHE_PERF_EN
        n_cmp++;
        if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_counters: hit=%0d miss=%0d want 0 0", hit_count, miss_count);
        end
`endif
        fetch_req = 1'b0;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_cold_miss();
        fetch_req = 1'b1;
        pc = 16'h0012;
        #1;
        n_cmp++;
        if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL cold_cyc0: valid=%b mem_req=%b want 0 0", instr_valid, mem_req);
        end
        step();
        n_cmp++;
        if (mem_req !== 1'b1 || mem_address !== 14'h0004) begin
            n_bad++;
            $display("FAIL cold_req: mem_req=%b addr=%h want 1 0004", mem_req, mem_address);
        end
        step();
        n_cmp++;
        if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL cold_fill: mem_req=%b valid=%b want 0 0", mem_req, instr_valid);
        end
        repeat (3) step();
        n_cmp++;
        if (instr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL cold_last_beat: valid=%b want 0", instr_valid);
        end
        step();
        n_cmp++;
        if (instr_valid !== 1'b1 || instr !== word(16'h0012)) begin
            n_bad++;
            $display("FAIL cold_hit_cyc6: valid=%b instr=%h want 1 %h", instr_valid, instr, word(16'h0012));
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] pcs [3];
        pcs = '{16'h0010, 16'h0011, 16'h0013};
        for (int i = 0; i < 3; i++) begin
            pc = pcs[i];
            #1;
            n_cmp++;
            if (instr_valid !== 1'b1 || instr !== word(pcs[i]) || mem_req !== 1'b0) begin
                n_bad++;
                $display("FAIL b2b_hit_%h: valid=%b instr=%h req=%b want 1 %h 0",
                         pcs[i], instr_valid, instr, mem_req, word(pcs[i]));
            end
            step();
        end
`ifdef I_CACHE_PERF_EN
        n_cmp++;
        if (miss_count !== 32'd1) begin
            n_bad++;
            $display("FAIL miss_count: got %0d want 1", miss_count);
        end
`endif
    endtask

    task automatic test_conflict();
        pc = 16'h0032;
        #1;
        n_cmp++;
        if (instr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL conflict_miss: valid=%b want 0", instr_valid);
        end
        step();
        n_cmp++;
        if (mem_req !== 1'b1 || mem_address !== 14'h000C) begin
            n_bad++;
            $display("FAIL conflict_req: req=%b addr=%h want 1 000C", mem_req, mem_address);
        end
        wait_hit(16'h0032, "conflict_fill");
        step();
        pc = 16'h0012;
        #1;
        n_cmp++;
        if (instr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL conflict_evicted: valid=%b want 0", instr_valid);
        end
        step();
        n_cmp++;
        if (mem_req !== 1'b1 || mem_address !== 14'h0004) begin
            n_bad++;
            $display("FAIL conflict_rereq: req=%b addr=%h want 1 0004", mem_req, mem_address);
        end
        wait_hit(16'h0012, "conflict_refill");
        step();
    endtask

    task automatic test_flush_fill();
        pc = 16'h0040;
        step();
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        step();
        n_cmp++;
        if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_fill_idle: valid=%b req=%b want 0 0", instr_valid, mem_req);
        end
        step();
        n_cmp++;
        if (mem_req !== 1'b1 || mem_address !== 14'h0010) begin
            n_bad++;
            $display("FAIL flush_fill_rereq: req=%b addr=%h want 1 0010", mem_req, mem_address);
        end
        wait_hit(16'h0040, "flush_refill");
        step();
    endtask

    task automatic test_flush_idle();
        pc = 16'h0012;
        flush = 1'b1;
        #1;
        step();
        flush = 1'b0;
        fetch_req = 1'b0;
        #1;
        n_cmp++;
        if (mem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_priority: req=%b want 0", mem_req);
        end
        fetch_req = 1'b1;
        pc = 16'h0040;
        #1;
        n_cmp++;
        if (instr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_cleared: valid=%b want 0", instr_valid);
        end
        wait_hit(16'h0040, "flush_idle_refill");
        step();
    endtask

    task automatic test_delayed_ack();
        ack_delay = 5;
        pc = 16'h0080;
        step();
        for (int k = 1; k <= 5; k++) begin
            if (k == 2) pc = 16'h0100;
            if (k == 5) pc = 16'h0080;
            #1;
            n_cmp++;
            if (mem_req !== 1'b1 || mem_address !== 14'h0020 || instr_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL delayed_req_%0d: req=%b addr=%h valid=%b want 1 0020 0",
                         k, mem_req, mem_address, instr_valid);
            end
            step();
        end
        wait_hit(16'h0080, "delayed_fill");
        pc = 16'h0083;
        #1;
        n_cmp++;
        if (instr_valid !== 1'b1 || instr !== word(16'h0083)) begin
            n_bad++;
            $display("FAIL delayed_word3: valid=%b instr=%h want 1 %h", instr_valid, instr, word(16'h0083));
        end
        ack_delay = 0;
        step();
    endtask

    task automatic test_reset_mid_fill();
        pc = 16'h00A3;
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_fill: req=%b valid=%b want 0 0", mem_req, instr_valid);
        end
`ifdef I_CACHE_PERF_EN
        n_cmp++;
        if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_mid_counters: hit=%0d miss=%0d want 0 0", hit_count, miss_count);
        end
`endif
        repeat (6) step();
        rst_n = 1'b1;
        pc = 16'h0080;
        #1;
        n_cmp++;
        if (instr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_miss: valid=%b want 0", instr_valid);
        end
        step();
        n_cmp++;
        if (mem_req !== 1'b1 || mem_address !== 14'h0020) begin
            n_bad++;
            $display("FAIL post_reset_req: req=%b addr=%h want 1 0020", mem_req, mem_address);
        end
        wait_hit(16'h0080, "post_reset_fill");
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        step();
        test_back_to_back();
        test_conflict();
        test_flush_fill();
        test_flush_idle();
        test_delayed_ack();
        test_reset_mid_fill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, want finish before 200000");
        $fatal(1);
    end
endmodule
